// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the data memory.
// slave = arbiter side, master = requester/memory side.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for the single-ported data memory.
// CPU has priority; a saturating wait counter guarantees DMA progress.
module mem_arbiter #(
  parameter int          AW       = 16,
  parameter int          DW       = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic {NORMAL, URGENT} prio_e;

  localparam logic [3:0] WMAX = 4'(MAX_WAIT);

  prio_e         state;
  logic [3:0]    wait_cnt;
  logic [3:0]    wait_nxt;
  logic          rd_q;
  logic          own_q;
  logic          rd_nxt;
  logic          own_nxt;
  logic          cg;
  logic          dg;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  // priority state is decoded from the saturated wait counter
  always_comb begin
    state = NORMAL;
    if (wait_cnt == WMAX) state = URGENT;
  end

  // grants, memory mux and next register values
  always_comb begin
    dg      = 1'b0;
    cg      = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (rst) begin
      dg = bus.dma_req & (~bus.cpu_req | (state == URGENT));
      cg = bus.cpu_req & ~dg;
    end
    unique case (1'b1)
      dg: begin
        m_we    = bus.dma_we;
        m_addr  = bus.dma_addr;
        m_wdata = bus.dma_wdata;
      end
      cg: begin
        m_we    = bus.cpu_we;
        m_addr  = bus.cpu_addr;
        m_wdata = bus.cpu_wdata;
      end
      default: ;
    endcase
    wait_nxt = wait_cnt;
    if (~bus.dma_req | dg) wait_nxt = 4'd0;
    else if (wait_cnt != WMAX) wait_nxt = wait_cnt + 4'd1;
    rd_nxt  = (cg & ~bus.cpu_we) | (dg & ~bus.dma_we);
    own_nxt = rd_nxt ? dg : own_q;
  end

  // wait counter and read-return tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 4'd0;
      rd_q     <= 1'b0;
      own_q    <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      rd_q     <= rd_nxt;
      own_q    <= own_nxt;
    end
  end

  assign bus.cpu_gnt    = cg;
  assign bus.dma_gnt    = dg;
  assign bus.cpu_stall  = bus.cpu_req & ~cg;
  assign bus.mem_en     = cg | dg;
  assign bus.mem_we     = m_we;
  assign bus.mem_addr   = m_addr;
  assign bus.mem_wdata  = m_wdata;
  assign bus.cpu_rvalid = rd_q & ~own_q;
  assign bus.dma_rvalid = rd_q & own_q;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int MAXW = 4;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(.AW(16), .DW(16), .MAX_WAIT(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] ram  [0:65535];
  logic [15:0] refm [0:65535];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous memory, one cycle read latency
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // transaction-level model state
  int          waited = 0;
  bit          pend_c = 0;
  bit          pend_d = 0;
  logic [15:0] pend_v = '0;

  // per-cycle comparison against the model
  always @(negedge clk) begin
    bit eg_d;
    bit eg_c;
    if (!rst) begin
      chk("rst_ctl", {bus.cpu_gnt, bus.dma_gnt, bus.mem_en, bus.mem_we},
          4'b0000);
      chk("rst_rv", {bus.cpu_rvalid, bus.dma_rvalid}, 2'b00);
      waited = 0;
      pend_c = 0;
      pend_d = 0;
    end else begin
      chk("rv", {bus.cpu_rvalid, bus.dma_rvalid}, {pend_c, pend_d});
      if (pend_c) chk("cpu_rdata", bus.cpu_rdata, pend_v);
      if (pend_d) chk("dma_rdata", bus.dma_rdata, pend_v);
      eg_d = bus.dma_req && (!bus.cpu_req || waited >= MAXW);
      eg_c = bus.cpu_req && !eg_d;
      chk("ctl", {bus.cpu_gnt, bus.dma_gnt, bus.cpu_stall, bus.mem_en},
          {eg_c, eg_d, bus.cpu_req && !eg_c, eg_c || eg_d});
      pend_c = 0;
      pend_d = 0;
      if (eg_d) begin
        chk("mux_d", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
            {bus.dma_we, bus.dma_addr, bus.dma_wdata});
        if (bus.dma_we) refm[bus.dma_addr] = bus.dma_wdata;
        else begin
          pend_d = 1;
          pend_v = refm[bus.dma_addr];
        end
      end else if (eg_c) begin
        chk("mux_c", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
            {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata});
        if (bus.cpu_we) refm[bus.cpu_addr] = bus.cpu_wdata;
        else begin
          pend_c = 1;
          pend_v = refm[bus.cpu_addr];
        end
      end else begin
        chk("mux_idle", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 33'd0);
      end
      if (bus.dma_req && !eg_d) waited = (waited < MAXW) ? waited + 1 : MAXW;
      else waited = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bit r, input bit w, input logic [15:0] a,
                         input logic [15:0] d);
    bus.cpu_req   = r;
    bus.cpu_we    = w;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic set_dma(input bit r, input bit w, input logic [15:0] a,
                         input logic [15:0] d);
    bus.dma_req   = r;
    bus.dma_we    = w;
    bus.dma_addr  = a;
    bus.dma_wdata = d;
  endtask

  task automatic new_cpu();
    set_cpu($urandom_range(3) != 0, 1'($urandom_range(1)),
            16'h0100 + 16'($urandom_range(7)), 16'($urandom));
  endtask

  task automatic new_dma();
    set_dma($urandom_range(2) != 0, 1'($urandom_range(1)),
            16'h0100 + 16'($urandom_range(7)), 16'($urandom));
  endtask

  initial begin
    int mask;
    int smask;
    int first;
    bit cg;
    bit dg;
    for (int i = 0; i < 65536; i++) begin
      ram[i]  = '0;
      refm[i] = '0;
    end
    bus.mem_rdata = '0;
    rst = 1'b0;
    set_cpu(1, 0, 16'h0000, 16'h0);
    set_dma(1, 0, 16'h0000, 16'h0);
    @(negedge clk);
    chk("reset_gnt", {bus.cpu_gnt, bus.dma_gnt, bus.mem_en}, 3'b000);
    chk("reset_rv", {bus.cpu_rvalid, bus.dma_rvalid}, 2'b00);
    set_cpu(0, 0, 16'h0, 16'h0);
    set_dma(0, 0, 16'h0, 16'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    tick();

    // CPU only: write then read back
    set_cpu(1, 1, 16'h0010, 16'h1234);
    @(negedge clk);
    chk("cpu_wr_gnt", {bus.cpu_gnt, bus.cpu_stall}, 2'b10);
    tick();
    set_cpu(1, 0, 16'h0010, 16'h0);
    @(negedge clk);
    chk("cpu_rd_gnt", {bus.cpu_gnt, bus.cpu_stall}, 2'b10);
    tick();
    set_cpu(0, 0, 16'h0, 16'h0);
    @(negedge clk);
    chk("cpu_rd_data", {bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_rdata},
        {2'b10, 16'h1234});
    tick();

    // DMA only: fill 0x4000..3, then back-to-back reads
    for (int i = 0; i < 4; i++) begin
      set_dma(1, 1, 16'h4000 + 16'(i), 16'hA000 + 16'(i));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_dma(1, 0, 16'h4000 + 16'(i), 16'h0);
      else set_dma(0, 0, 16'h0, 16'h0);
      @(negedge clk);
      if (i < 4) chk("dma_rd_gnt", bus.dma_gnt, 1'b1);
      if (i > 0)
        chk("dma_rd_data", {bus.dma_rvalid, bus.cpu_rvalid, bus.dma_rdata},
            {2'b10, 16'hA000 + 16'(i - 1)});
      tick();
    end

    // starvation: both requesting continuously
    mask  = 0;
    smask = 0;
    set_cpu(1, 0, 16'h0020, 16'h0);
    set_dma(1, 0, 16'h0030, 16'h0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (bus.dma_gnt) mask |= (1 << c);
      if (bus.cpu_stall) smask |= (1 << c);
      chk("wait_le_max", 32'(dut.wait_cnt <= 4'(MAXW)), 32'd1);
      tick();
    end
    chk("starve_gnt", mask, (1 << 5) | (1 << 10) | (1 << 15));
    chk("starve_stall", smask, (1 << 5) | (1 << 10) | (1 << 15));
    set_cpu(0, 0, 16'h0, 16'h0);
    set_dma(0, 0, 16'h0, 16'h0);
    tick();
    tick();

    // reset during an outstanding CPU read
    set_cpu(1, 0, 16'h0010, 16'h0);
    set_dma(1, 0, 16'h0030, 16'h0);
    @(negedge clk);
    chk("rr_cpu_gnt", {bus.cpu_gnt, bus.dma_gnt}, 2'b10);
    tick();
    set_cpu(0, 0, 16'h0, 16'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rr_rv_drop", bus.cpu_rvalid, 1'b0);
    chk("rr_wait_clr", dut.wait_cnt, 4'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rr_post_gnt", {bus.dma_gnt, bus.cpu_rvalid}, 2'b10);
    tick();
    set_dma(0, 0, 16'h0, 16'h0);
    tick();

    // dropped DMA request clears the wait counter
    set_cpu(1, 0, 16'h0020, 16'h0);
    set_dma(1, 0, 16'h0030, 16'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("drop_no_gnt", bus.dma_gnt, 1'b0);
      tick();
    end
    set_dma(0, 0, 16'h0, 16'h0);
    tick();
    set_dma(1, 0, 16'h0030, 16'h0);
    first = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) chk("drop_wait_zero", dut.wait_cnt, 4'd0);
      if (bus.dma_gnt && first == 0) first = c;
      tick();
    end
    chk("drop_full_wait", first, 5);
    set_cpu(0, 0, 16'h0, 16'h0);
    set_dma(0, 0, 16'h0, 16'h0);
    tick();

    // random traffic honouring the hold-until-grant rule
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      cg = bus.cpu_gnt;
      dg = bus.dma_gnt;
      tick();
      if (!bus.cpu_req || cg) new_cpu();
      if (!bus.dma_req || dg) new_dma();
      else if ($urandom_range(15) == 0) bus.dma_req = 1'b0;
    end
    set_cpu(0, 0, 16'h0, 16'h0);
    set_dma(0, 0, 16'h0, 16'h0);
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
